decoder: RTL and testbench
==========================

// Module: decoder
// PURPOSE
//  RV32I(+M) instruction decoder for the rv32im core, between fetch and register-file read/execute.
//  Splits a 32-bit instruction into raw fields, builds the sign-extended immediate, selects an ALU/MDU op.
//  Decode logic is combinational; all outputs are registered (one pipeline stage).
// PARAMETERS
//  XLEN  32  datapath/immediate width (only 32 supported)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   instruction is valid this cycle
//  instruction  in   32  raw instruction word
//  out_valid    out  1   registered in_valid
//  opcode       out  7   instruction[6:0]
//  rd           out  5   instruction[11:7]
//  funct3       out  3   instruction[14:12]
//  rs1          out  5   instruction[19:15]
//  rs2          out  5   instruction[24:20]
//  funct7       out  7   instruction[31:25]
//  imm          out  32  decoded immediate
//  alu_op       out  4   ALU op, or MDU op when mdu_sel=1
//  mdu_sel      out  1   M-extension op (MUL/DIV/REM family)
//  illegal      out  1   unsupported opcode/funct combination
// BEHAVIOUR
//  - All outputs are registered on the rising clk edge. Latency is 1 cycle; no stall.
//  - rst_n low: every output is 0 immediately, including out_valid and illegal.
//  - With in_valid=0, fields still decode; out_valid=0 and illegal=0.
//  - rd, rs1, rs2, funct3, funct7 and opcode are raw bit slices for every format.
//  - imm by opcode:
//    - 0010011 / 0000011 / 1100111: I-type, sext(ins[31:20]).
//    - 0010011 with funct3 001/101 (shifts): {27'b0, ins[24:20]}.
//    - 0100011: S-type, sext({ins[31:25], ins[11:7]}).
//    - 1100011: B-type, sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}).
//    - 1101111: J-type, sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}).
//    - 0110111 / 0010111: U-type, {ins[31:12], 12'b0}.
//    - 0110011 and illegal: 0.
//  - alu_op codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 PASSB=10; 11-15 reserved.
//  - R-type (funct7 0000000/0100000) and OP-IMM map by funct3.
//    - funct7[5] selects SUB (R-type only) and SRA/SRAI.
//    - Any other funct7 is illegal; SLLI requires funct7=0.
//  - Loads, stores, JAL, JALR and AUIPC use ADD. LUI uses PASSB.
//  - Branches:
//    - BEQ/BNE use SUB.
//    - BLT/BGE use SLT.
//    - BLTU/BGEU use SLTU.
//    - funct3 010/011 is illegal.
//  - Illegal opcode: alu_op=ADD, imm=0, mdu_sel=0, illegal=in_valid.
// CONFIGURATION
//  RV32M_EN defined:
//    - opcode 0110011 with funct7=0000001 gives mdu_sel=1 and alu_op={1'b0, funct3}.
//    - Codes: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7.
//  RV32M_EN undefined: funct7=0000001 is illegal and mdu_sel is tied to 0.
// STRUCTURE
//  - Package decoder_pkg holds:
//    - the opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
//    - the alu_op_e and mdu_op_e enums.
//  - Sub-module imm_gen: combinational, instruction in, imm out.
//  - Top module: op/illegal decode plus the output register stage.
// TESTING
//  - ADD x1,x2,x3 (0x003100B3) -> next cycle: rd=1 rs1=2 rs2=3, alu_op=0, imm=0, illegal=0.
//  - SUB x4,x5,x6 (0x40628233) -> alu_op=1.
//  - ADDI x1,x2,100 (0x06410093) -> imm=0x00000064, alu_op=0.
//  - XORI x7,x8,-1 (0xFFF44393) -> imm=0xFFFFFFFF, alu_op=4.
//  - SLLI x9,x10,4 (0x00451493) -> imm=0x00000004, alu_op=5.
//  - SW x15,40(x16) (0x02F82423) -> imm=0x28, rs2=15, rs1=16.
//  - BEQ x17,x18,8 (0x01288463) -> imm=0x00000008, alu_op=1.
//  - BNE x19,x20,-16 (0xFF4998E3) -> imm=0xFFFFFFF0.
//  - JAL x1,100 (0x064000EF) -> imm=0x64.
//  - LUI x4,0x12345 (0x12345237) -> imm=0x12345000, alu_op=10.
//  - AUIPC x5,0xABCDE (0xABCDE297) -> imm=0xABCDE000, alu_op=0.
//  - MUL x25,x26,x27 (0x03BD0CB3):
//    - RV32M_EN defined -> mdu_sel=1, alu_op=0.
//    - RV32M_EN undefined -> illegal=1.
//  - DIV x28,x29,x30 (0x03EECE33), RV32M_EN defined -> mdu_sel=1, alu_op=4.
//  - Opcode 0x7F with in_valid=1 -> illegal=1, imm=0.
//  - rst_n low mid-stream -> all outputs 0 at once.
//  - After rst_n is released -> first decoded instruction appears one cycle after it is applied.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared opcode constants and operation encodings for the rv32im decoder.
package decoder_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MDU  = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate builder: selects the immediate format from the opcode.
module imm_gen
   import decoder_pkg::*;
(
   input  logic [31:0] instruction,
   output logic [31:0] imm
);

   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];

   always_comb begin
      imm = '0;
      case (opcode)
         OP_IMM: begin
            // Shift-immediates carry a 5-bit shamt, not a signed constant.
            if (funct3 == 3'b001 || funct3 == 3'b101)
               imm = {27'b0, instruction[24:20]};
            else
               imm = {{20{instruction[31]}}, instruction[31:20]};
         end
         OP_LOAD, OP_JALR:
            imm = {{20{instruction[31]}}, instruction[31:20]};
         OP_STORE:
            imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         OP_BRANCH:
            imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
         OP_JAL:
            imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {instruction[31:12], 12'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/decoder.sv
// RV32I(+M) decoder with one registered output stage.
// Define RV32M_EN to decode the M-extension (funct7=0000001 on the R opcode).
module decoder
   import decoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] instruction,
   output logic        out_valid,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  funct7,
   output logic [31:0] imm,
   output logic [3:0]  alu_op,
   output logic        mdu_sel,
   output logic        illegal
);

   // Streaming interface: in_valid qualifies instruction each cycle; out_valid
   // follows it one cycle later. There is no ready/back-pressure, so no stall.

   logic [6:0]  op_w;
   logic [2:0]  f3_w;
   logic [6:0]  f7_w;
   logic [31:0] imm_raw;

   logic        out_valid_d, out_valid_q;
   logic [31:0] ins_d, ins_q;
   logic [31:0] imm_d, imm_q;
   logic [3:0]  alu_op_d, alu_op_q;
   logic        mdu_sel_d, mdu_sel_q;
   logic        illegal_d, illegal_q;
   logic        bad;

   assign op_w = instruction[6:0];
   assign f3_w = instruction[14:12];
   assign f7_w = instruction[31:25];

   imm_gen u_imm_gen (
      .instruction (instruction),
      .imm         (imm_raw)
   );

   always_comb begin
      bad      = 1'b0;
      alu_op_d = ALU_ADD;
      mdu_sel_d = 1'b0;
      case (op_w)
         OP_R: begin
            if (f7_w == F7_BASE || f7_w == F7_ALT) begin
               case (f3_w)
                  3'b000: alu_op_d = f7_w[5] ? ALU_SUB : ALU_ADD;
                  3'b001: alu_op_d = ALU_SLL;
                  3'b010: alu_op_d = ALU_SLT;
                  3'b011: alu_op_d = ALU_SLTU;
                  3'b100: alu_op_d = ALU_XOR;
                  3'b101: alu_op_d = f7_w[5] ? ALU_SRA : ALU_SRL;
                  3'b110: alu_op_d = ALU_OR;
                  default: alu_op_d = ALU_AND;
               endcase
               // The alternate funct7 only exists for SUB and SRA.
               if (f7_w[5] && f3_w != 3'b000 && f3_w != 3'b101)
                  bad = 1'b1;
            end
`ifdef RV32M_EN
            else if (f7_w == F7_MDU) begin
               mdu_sel_d = 1'b1;
               alu_op_d  = {1'b0, f3_w};
            end
`endif
            else begin
               bad = 1'b1;
            end
         end
         OP_IMM: begin
            case (f3_w)
               3'b000: alu_op_d = ALU_ADD;
               3'b001: begin
                  alu_op_d = ALU_SLL;
                  bad      = (f7_w != F7_BASE);
               end
               3'b010: alu_op_d = ALU_SLT;
               3'b011: alu_op_d = ALU_SLTU;
               3'b100: alu_op_d = ALU_XOR;
               3'b101: begin
                  alu_op_d = f7_w[5] ? ALU_SRA : ALU_SRL;
                  bad      = (f7_w != F7_BASE && f7_w != F7_ALT);
               end
               3'b110: alu_op_d = ALU_OR;
               default: alu_op_d = ALU_AND;
            endcase
         end
         OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC:
            alu_op_d = ALU_ADD;
         OP_LUI:
            alu_op_d = ALU_PASSB;
         OP_BRANCH: begin
            case (f3_w)
               3'b000, 3'b001: alu_op_d = ALU_SUB;
               3'b100, 3'b101: alu_op_d = ALU_SLT;
               3'b110, 3'b111: alu_op_d = ALU_SLTU;
               default:        bad      = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase

      if (bad) begin
         alu_op_d  = ALU_ADD;
         mdu_sel_d = 1'b0;
      end
      imm_d       = bad ? 32'd0 : imm_raw;
      illegal_d   = bad & in_valid;
      out_valid_d = in_valid;
      ins_d       = instruction;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         ins_q       <= '0;
         imm_q       <= '0;
         alu_op_q    <= '0;
         mdu_sel_q   <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         ins_q       <= ins_d;
         imm_q       <= imm_d;
         alu_op_q    <= alu_op_d;
         mdu_sel_q   <= mdu_sel_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = ins_q[6:0];
   assign rd        = ins_q[11:7];
   assign funct3    = ins_q[14:12];
   assign rs1       = ins_q[19:15];
   assign rs2       = ins_q[24:20];
   assign funct7    = ins_q[31:25];
   assign imm       = imm_q;
   assign alu_op    = alu_op_q;
   assign mdu_sel   = mdu_sel_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: hand-computed vectors checked with immediate assertions.
module tb_decoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] instruction;
   logic        out_valid;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic [3:0]  alu_op;
   logic        mdu_sel;
   logic        illegal;

   int tests_run;
   int tests_failed;

   decoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .instruction (instruction),
      .out_valid   (out_valid),
      .opcode      (opcode),
      .rd          (rd),
      .funct3      (funct3),
      .rs1         (rs1),
      .rs2         (rs2),
      .funct7      (funct7),
      .imm         (imm),
      .alu_op      (alu_op),
      .mdu_sel     (mdu_sel),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive at the falling edge, then sample 1 time unit after the next rising edge.
   task automatic step(input logic [31:0] ins, input logic v);
      @(negedge clk);
      instruction = ins;
      in_valid    = v;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   {31'b0, out_valid}, 32'd0);
      check({tag, "_opcode"},  {25'b0, opcode},    32'd0);
      check({tag, "_rd"},      {27'b0, rd},        32'd0);
      check({tag, "_rs1"},     {27'b0, rs1},       32'd0);
      check({tag, "_rs2"},     {27'b0, rs2},       32'd0);
      check({tag, "_imm"},     imm,                32'd0);
      check({tag, "_alu"},     {28'b0, alu_op},    32'd0);
      check({tag, "_mdu"},     {31'b0, mdu_sel},   32'd0);
      check({tag, "_illegal"}, {31'b0, illegal},   32'd0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b1;
      instruction  = 32'h003100B3;

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ADD x1,x2,x3
      step(32'h003100B3, 1'b1);
      check("add_valid",   {31'b0, out_valid}, 32'd1);
      check("add_opcode",  {25'b0, opcode},    32'h33);
      check("add_rd",      {27'b0, rd},        32'd1);
      check("add_rs1",     {27'b0, rs1},       32'd2);
      check("add_rs2",     {27'b0, rs2},       32'd3);
      check("add_alu",     {28'b0, alu_op},    32'd0);
      check("add_imm",     imm,                32'd0);
      check("add_illegal", {31'b0, illegal},   32'd0);

      // SUB x4,x5,x6
      step(32'h40628233, 1'b1);
      check("sub_alu",    {28'b0, alu_op}, 32'd1);
      check("sub_funct7", {25'b0, funct7}, 32'h20);
      check("sub_rd",     {27'b0, rd},     32'd4);

      // ADDI x1,x2,100
      step(32'h06410093, 1'b1);
      check("addi_imm", imm,             32'h00000064);
      check("addi_alu", {28'b0, alu_op}, 32'd0);

      // XORI x7,x8,-1
      step(32'hFFF44393, 1'b1);
      check("xori_imm",    imm,              32'hFFFFFFFF);
      check("xori_alu",    {28'b0, alu_op},  32'd4);
      check("xori_funct3", {29'b0, funct3},  32'd4);

      // SLLI x9,x10,4
      step(32'h00451493, 1'b1);
      check("slli_imm", imm,             32'h00000004);
      check("slli_alu", {28'b0, alu_op}, 32'd5);

      // SRAI x9,x10,4: shamt immediate, not sign-extended funct7 bits
      step(32'h40455493, 1'b1);
      check("srai_imm", imm,             32'h00000004);
      check("srai_alu", {28'b0, alu_op}, 32'd7);

      // SW x15,40(x16)
      step(32'h02F82423, 1'b1);
      check("sw_imm", imm,          32'h00000028);
      check("sw_rs2", {27'b0, rs2}, 32'd15);
      check("sw_rs1", {27'b0, rs1}, 32'd16);
      check("sw_alu", {28'b0, alu_op}, 32'd0);

      // BEQ x17,x18,8
      step(32'h01288463, 1'b1);
      check("beq_imm", imm,             32'h00000008);
      check("beq_alu", {28'b0, alu_op}, 32'd1);

      // BNE x19,x20,-16
      step(32'hFF4998E3, 1'b1);
      check("bne_imm", imm,             32'hFFFFFFF0);
      check("bne_alu", {28'b0, alu_op}, 32'd1);

      // Branch with funct3=010 is illegal; imm forced to 0
      step(32'h0128A463, 1'b1);
      check("br010_illegal", {31'b0, illegal}, 32'd1);
      check("br010_imm",     imm,              32'd0);
      check("br010_alu",     {28'b0, alu_op},  32'd0);

      // JAL x1,100
      step(32'h064000EF, 1'b1);
      check("jal_imm", imm,             32'h00000064);
      check("jal_alu", {28'b0, alu_op}, 32'd0);

      // LUI x4,0x12345
      step(32'h12345237, 1'b1);
      check("lui_imm", imm,             32'h12345000);
      check("lui_alu", {28'b0, alu_op}, 32'd10);

      // AUIPC x5,0xABCDE
      step(32'hABCDE297, 1'b1);
      check("auipc_imm", imm,             32'hABCDE000);
      check("auipc_alu", {28'b0, alu_op}, 32'd0);

      // MUL x25,x26,x27
      step(32'h03BD0CB3, 1'b1);
`ifdef RV32M_EN
      check("mul_mdu",     {31'b0, mdu_sel}, 32'd1);
      check("mul_alu",     {28'b0, alu_op},  32'd0);
      check("mul_illegal", {31'b0, illegal}, 32'd0);
`else
      check("mul_mdu",     {31'b0, mdu_sel}, 32'd0);
      check("mul_illegal", {31'b0, illegal}, 32'd1);
      check("mul_alu",     {28'b0, alu_op},  32'd0);
`endif

      // DIV x28,x29,x30
      step(32'h03EECE33, 1'b1);
`ifdef RV32M_EN
      check("div_mdu", {31'b0, mdu_sel}, 32'd1);
      check("div_alu", {28'b0, alu_op},  32'd4);
`else
      check("div_mdu",     {31'b0, mdu_sel}, 32'd0);
      check("div_illegal", {31'b0, illegal}, 32'd1);
`endif

      // Unknown opcode 0x7F
      step(32'h0000007F, 1'b1);
      check("op7f_illegal", {31'b0, illegal}, 32'd1);
      check("op7f_imm",     imm,              32'd0);
      check("op7f_alu",     {28'b0, alu_op},  32'd0);

      // Same word with in_valid low: fields decode, no valid, no illegal
      step(32'h0000007F, 1'b0);
      check("inv_valid",   {31'b0, out_valid}, 32'd0);
      check("inv_illegal", {31'b0, illegal},   32'd0);
      check("inv_opcode",  {25'b0, opcode},    32'h7F);

      // Asynchronous reset mid-stream
      step(32'h06410093, 1'b1);
      check("pre_rst_imm", imm, 32'h00000064);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");

      // Release, then first instruction appears one cycle after it is applied
      @(negedge clk);
      rst_n       = 1'b1;
      instruction = 32'h12345237;
      in_valid    = 1'b1;
      #1;
      check("post_rst_hold_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("post_rst_valid", {31'b0, out_valid}, 32'd1);
      check("post_rst_imm",   imm,                32'h12345000);
      check("post_rst_alu",   {28'b0, alu_op},    32'd10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
